// File: rtl/trd_pkg.sv
// Shared thread-control definitions for the 8-thread pipeline.
// Contents: thread count and field widths, the command encoding (trd_ctrl_e)
// shared by the execute and memory stages, the per-thread run state
// (trd_state_e), the default argument register, and the registered payloads
// of the start-PC redirect and the argument write.
package trd_pkg;

  localparam int unsigned NUM_TRD = 8;
  localparam int unsigned TRD_W   = 3;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;

  localparam logic [REG_W-1:0] ARG_REG_DEF = 5'd1;

  typedef enum logic [CTRL_W-1:0] {
    TRD_CTRL_NONE  = 3'd0,
    TRD_CTRL_SPAWN = 3'd1,
    TRD_CTRL_KILL  = 3'd2,
    TRD_CTRL_EXIT  = 3'd3,
    TRD_CTRL_JOIN  = 3'd4
  } trd_ctrl_e;

  // WAIT is only ever entered when TRD_JOIN_EN is defined.
  typedef enum logic [1:0] {
    TRD_ST_IDLE = 2'd0,
    TRD_ST_RUN  = 2'd1,
    TRD_ST_WAIT = 2'd2
  } trd_state_e;

  typedef struct packed {
    logic [TRD_W-1:0] trd;
    logic [PC_W-1:0]  pc;
  } trd_start_t;

  typedef struct packed {
    logic [TRD_W-1:0]  trd;
    logic [DATA_W-1:0] data;
  } trd_arg_t;

endpackage

// File: rtl/trd_rr_arb.sv
// Combinational round-robin pick for the fetch scheduler.
// Ports:
//   req_i   - one request bit per thread (thread is RUN)
//   last_i  - last granted thread ID
//   gnt_c_o - first requesting thread strictly after last_i, wrapping 7->0;
//             equals last_i when nothing requests
//   vld_c_o - some thread requests
module trd_rr_arb
  import trd_pkg::*;
(
  input  logic [NUM_TRD-1:0] req_i,
  input  logic [TRD_W-1:0]   last_i,
  output logic [TRD_W-1:0]   gnt_c_o,
  output logic               vld_c_o
);

  logic [TRD_W-1:0] idx;

  // Scan last+1 .. last+8; the final step wraps back onto last itself.
  always_comb begin
    gnt_c_o = last_i;
    vld_c_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_TRD; i++) begin
      idx = last_i + TRD_W'(i);
      if (!vld_c_o && req_i[idx]) begin
        gnt_c_o = idx;
        vld_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trd_mgr.sv
// Thread manager: per-thread run state, thread-control command handling
// (SPAWN/KILL/EXIT and optional JOIN), round-robin fetch selection, and the
// start-PC / argument-write side effects of a spawn.
// Build option: define TRD_JOIN_EN to add JOIN, the WAIT state and the
// per-thread wait targets; otherwise JOIN is reported as an illegal command.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   stall                   - freezes the scheduler pointer and its outputs
//   trd_mem, trd_ctrl_mem,
//   obj_trd_mem, new_pc_mem,
//   new_data_mem            - command from the memory stage
//   trd_sel_if, trd_vld_if  - thread to fetch and its valid
//   start_en/trd/pc         - start-PC load pulse for a spawned thread
//   arg_wr_en/trd/reg/data  - argument register write pulse
//   kill_en, kill_trd       - flush pulse for a killed/exited thread
//   cmd_err                 - illegal command pulse
//   halt                    - every thread IDLE
module trd_mgr
  import trd_pkg::*;
#(
  parameter int unsigned      NUM_TRD = 8,
  parameter logic [PC_W-1:0]  RST_PC  = 32'h0,
  parameter logic [REG_W-1:0] ARG_REG = 5'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [TRD_W-1:0]  trd_mem,
  input  logic [CTRL_W-1:0] trd_ctrl_mem,
  input  logic [TRD_W-1:0]  obj_trd_mem,
  input  logic [PC_W-1:0]   new_pc_mem,
  input  logic [DATA_W-1:0] new_data_mem,
  output logic [TRD_W-1:0]  trd_sel_if,
  output logic              trd_vld_if,
  output logic              start_en,
  output logic [TRD_W-1:0]  start_trd,
  output logic [PC_W-1:0]   start_pc,
  output logic              arg_wr_en,
  output logic [TRD_W-1:0]  arg_trd,
  output logic [REG_W-1:0]  arg_reg,
  output logic [DATA_W-1:0] arg_data,
  output logic              kill_en,
  output logic [TRD_W-1:0]  kill_trd,
  output logic              cmd_err,
  output logic              halt
);

  trd_state_e       st_q [NUM_TRD];
  trd_state_e       st_d [NUM_TRD];
`ifdef TRD_JOIN_EN
  logic [TRD_W-1:0] wait_tgt_q [NUM_TRD];
  logic [TRD_W-1:0] wait_tgt_d [NUM_TRD];
`endif

  logic             start_en_q, start_en_d;
  trd_start_t       start_q, start_d;
  logic             arg_en_q, arg_en_d;
  trd_arg_t         arg_q, arg_d;
  logic             kill_en_q, kill_en_d;
  logic [TRD_W-1:0] kill_trd_q, kill_trd_d;
  logic             err_q, err_d;
  logic             halt_q, halt_d;
  logic [TRD_W-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;

  logic [NUM_TRD-1:0] req_c;
  logic [TRD_W-1:0]   gnt_c;
  logic               gnt_vld_c;

  // Command decode and thread state next-state.
  always_comb begin
    st_d       = st_q;
    start_en_d = 1'b0;
    arg_en_d   = 1'b0;
    kill_en_d  = 1'b0;
    err_d      = 1'b0;
    start_d    = start_q;
    arg_d      = arg_q;
    kill_trd_d = kill_trd_q;
`ifdef TRD_JOIN_EN
    wait_tgt_d = wait_tgt_q;
    // Release waiters whose target is already IDLE; a KILL below overrides.
    for (int unsigned i = 0; i < NUM_TRD; i++) begin
      if (st_q[i] == TRD_ST_WAIT && st_q[wait_tgt_q[i]] == TRD_ST_IDLE) begin
        st_d[i] = TRD_ST_RUN;
      end
    end
`endif

    case (trd_ctrl_mem)
      TRD_CTRL_NONE: ;
      TRD_CTRL_SPAWN: begin
        if (st_q[obj_trd_mem] == TRD_ST_IDLE) begin
          st_d[obj_trd_mem] = TRD_ST_RUN;
          start_en_d        = 1'b1;
          start_d.trd       = obj_trd_mem;
          start_d.pc        = new_pc_mem;
          arg_en_d          = 1'b1;
          arg_d.trd         = obj_trd_mem;
          arg_d.data        = new_data_mem;
        end else begin
          err_d = 1'b1;
        end
      end
      // Self-kill is an exit; killing an IDLE thread is a silent no-op.
      TRD_CTRL_KILL: begin
        if (obj_trd_mem == trd_mem || st_q[obj_trd_mem] != TRD_ST_IDLE) begin
          st_d[obj_trd_mem] = TRD_ST_IDLE;
          kill_en_d         = 1'b1;
          kill_trd_d        = obj_trd_mem;
        end
      end
      TRD_CTRL_EXIT: begin
        st_d[trd_mem] = TRD_ST_IDLE;
        kill_en_d     = 1'b1;
        kill_trd_d    = trd_mem;
      end
`ifdef TRD_JOIN_EN
      TRD_CTRL_JOIN: begin
        if (obj_trd_mem == trd_mem) begin
          err_d = 1'b1;
        end else if (st_q[obj_trd_mem] != TRD_ST_IDLE) begin
          st_d[trd_mem]       = TRD_ST_WAIT;
          wait_tgt_d[trd_mem] = obj_trd_mem;
        end
      end
`endif
      default: err_d = 1'b1;
    endcase
  end

  // Requests exclude threads leaving RUN this cycle and threads that only
  // enter RUN this cycle, so kills take effect at once and spawns next cycle.
  always_comb begin
    req_c  = '0;
    halt_d = 1'b1;
    for (int unsigned i = 0; i < NUM_TRD; i++) begin
      req_c[i] = (st_q[i] == TRD_ST_RUN) && (st_d[i] == TRD_ST_RUN);
      if (st_d[i] != TRD_ST_IDLE) begin
        halt_d = 1'b0;
      end
    end
  end

  trd_rr_arb u_arb (
    .req_i   (req_c),
    .last_i  (sel_q),
    .gnt_c_o (gnt_c),
    .vld_c_o (gnt_vld_c)
  );

  // Stall freezes only the scheduler; commands keep being processed.
  always_comb begin
    sel_d = stall ? sel_q : gnt_c;
    vld_d = stall ? vld_q : gnt_vld_c;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TRD; i++) begin
        st_q[i] <= (i == 0) ? TRD_ST_RUN : TRD_ST_IDLE;
`ifdef TRD_JOIN_EN
        wait_tgt_q[i] <= '0;
`endif
      end
      start_en_q <= 1'b0;
      start_q    <= '{trd: '0, pc: RST_PC};
      arg_en_q   <= 1'b0;
      arg_q      <= '0;
      kill_en_q  <= 1'b0;
      kill_trd_q <= '0;
      err_q      <= 1'b0;
      halt_q     <= 1'b0;
      sel_q      <= '0;
      vld_q      <= 1'b1;
    end else begin
      st_q       <= st_d;
`ifdef TRD_JOIN_EN
      wait_tgt_q <= wait_tgt_d;
`endif
      start_en_q <= start_en_d;
      start_q    <= start_d;
      arg_en_q   <= arg_en_d;
      arg_q      <= arg_d;
      kill_en_q  <= kill_en_d;
      kill_trd_q <= kill_trd_d;
      err_q      <= err_d;
      halt_q     <= halt_d;
      sel_q      <= sel_d;
      vld_q      <= vld_d;
    end
  end

  assign trd_sel_if = sel_q;
  assign trd_vld_if = vld_q;
  assign start_en   = start_en_q;
  assign start_trd  = start_q.trd;
  assign start_pc   = start_q.pc;
  assign arg_wr_en  = arg_en_q;
  assign arg_trd    = arg_q.trd;
  assign arg_reg    = ARG_REG;
  assign arg_data   = arg_q.data;
  assign kill_en    = kill_en_q;
  assign kill_trd   = kill_trd_q;
  assign cmd_err    = err_q;
  assign halt       = halt_q;

endmodule

// File: doc/trd_mgr.md
# trd_mgr

Thread manager for the 8-thread pipeline. Consumes the thread-control commands that the execute stage registers into the memory stage, and keeps the per-thread run state: spawn, kill, exit, and optional join. It round-robin selects the thread the fetch stage issues each cycle. It also emits the start-PC redirect and initial-argument register write for newly spawned threads.

## Interface
Parameters:
- NUM_TRD, 8, thread count; thread IDs are 3 bits.
- RST_PC, 32'h0, reset PC of thread 0.
- ARG_REG, 5'd1, register that receives a spawned thread's argument.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freezes the scheduler pointer only.
- trd_mem  in  3  thread issuing the command.
- trd_ctrl_mem  in  3  command: 0 NONE, 1 SPAWN, 2 KILL, 3 EXIT, 4 JOIN.
- obj_trd_mem  in  3  target thread.
- new_pc_mem  in  32  start PC for SPAWN.
- new_data_mem  in  32  argument for SPAWN.
- trd_sel_if  out  3  thread to fetch this cycle.
- trd_vld_if  out  1  trd_sel_if is valid.
- start_en  out  1  one-cycle pulse: load start_pc into the PC of start_trd.
- start_trd  out  3  target thread of the start load.
- start_pc  out  32  start PC.
- arg_wr_en  out  1  one-cycle register-file write pulse.
- arg_trd  out  3  thread whose register is written.
- arg_reg  out  5  register written; always ARG_REG.
- arg_data  out  32  value written.
- kill_en  out  1  one-cycle pulse: flush in-flight instructions of kill_trd.
- kill_trd  out  3  thread to flush.
- cmd_err  out  1  one-cycle pulse: illegal command, ignored.
- halt  out  1  all threads IDLE.

## Operation
- Per-thread state: IDLE, RUN, WAIT (WAIT only with join). Reset state: thread 0 RUN, all others IDLE.
- SPAWN: target IDLE → RUN; pulse start_en(obj, new_pc) and arg_wr_en(obj, ARG_REG, new_data). Target not IDLE → cmd_err, no change.
- KILL: target RUN or WAIT → IDLE; pulse kill_en(obj). Target already IDLE → no effect, no error. KILL of self behaves as EXIT.
- EXIT: issuing thread → IDLE; pulse kill_en(trd_mem).
- JOIN: issuing thread → WAIT and records wait_tgt = obj.
  - Target already IDLE → no state change.
  - obj == trd_mem → cmd_err.
  - A WAIT thread returns to RUN in the cycle after its wait_tgt becomes IDLE.
- Codes 5–7 → cmd_err.
- Commands arrive at most one per cycle. trd_ctrl_mem is ignored when 0. Commands are processed even while stall is high.
- Scheduler: rotating pointer. trd_sel_if = first RUN thread strictly after the last-issued thread, wrapping 7→0.
  - No RUN thread → trd_vld_if=0 and trd_sel_if holds its last value.
  - stall=1 → pointer and outputs hold.
- halt = all IDLE. Leaving halt requires reset, because no thread remains to issue a SPAWN.

## Timing
- Reset values: all pulses 0; trd_sel_if=0; trd_vld_if=1; start_pc, start_trd, arg_trd, arg_data, kill_trd = 0; arg_reg=ARG_REG; halt=0.
- Command sampled at edge N. State update and all pulses are registered and visible after edge N, high for exactly one cycle.
- The scheduler uses the updated state from cycle N+1, so a spawned thread is selectable at the earliest in N+1.
- A killed or exited thread is never selected after edge N. trd_sel_if is registered, so a command at edge N affects the selection from cycle N+1 onward.
- Simultaneous join release and a KILL of the waiting thread in the same cycle → the KILL wins (IDLE).
- Reset mid-operation clears all state immediately (asynchronous). No pulses are emitted on release.

## Configuration
- TRD_JOIN_EN defined: JOIN, the WAIT state and the wait_tgt registers are present.
- TRD_JOIN_EN undefined: code 4 → cmd_err, WAIT logic removed, states reduce to IDLE and RUN.

## Structure
- Shared package trd_pkg: NUM_TRD, trd_ctrl_e (command encodings), trd_state_e, ARG_REG default. The execute and memory stages import the same trd_ctrl_e.
- One sub-module, trd_rr_arb: 8-bit request vector plus last-grant → grant ID and valid, combinational. trd_mgr registers its output.

## Test plan
- Reset → trd_sel_if=0, trd_vld_if=1, and trd_sel_if stays 0 for 5 cycles.
- SPAWN obj=3, pc=32'h100, data=32'hAB from thread 0 → next cycle start_en=1 with start_trd=3/start_pc=32'h100, arg_wr_en=1 with arg_trd=3/arg_data=32'hAB; selection then alternates 0,3,0,3.
- SPAWN obj=3 while 3 is RUN → cmd_err=1 for one cycle, no start_en, schedule unchanged.
- Threads 0,2,5 RUN, then KILL 2 → kill_en=1 with kill_trd=2; sequence becomes 0,5,0,5; stall=1 for 3 cycles holds trd_sel_if.
- JOIN from 0 on obj=4 while 4 RUN → 0 leaves the rotation; thread 4 EXIT → 0 is back in rotation one cycle after 4 goes IDLE. Without TRD_JOIN_EN the same JOIN gives cmd_err.
- EXIT from the only RUN thread → trd_vld_if=0, halt=1; rst_n low mid-cycle → immediate reset values.
